// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle add/sub/mul/div controller built around one shared N-bit adder
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request pulse, sampled only in IDLE
//   op         00 add, 01 sub, 10 mul, 11 div (sampled with start)
//   a, b       unsigned N-bit operands (sampled with start)
//   busy       high in ITER and DONE
//   done       one-cycle completion pulse (DONE state)
//   result     sum / difference / product low bits / quotient
//   remainder  div remainder, 0 for other ops
//   err        add carry, sub borrow, mul overflow or div-by-zero
module calc_sequencer #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] remainder,
    output logic         err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam int CW = $clog2(N + 1);

    logic [1:0]     state;
    logic [1:0]     op_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [CW-1:0]  cnt;
    // mul: {partial product high half, multiplier shifting out at the LSB}
    // div: {partial remainder, dividend shifting out at the MSB / quotient shifting in at the LSB}
    logic [2*N-1:0] prod;

    logic [N-1:0]   adder_x;
    logic [N-1:0]   adder_y;
    logic           adder_inv;
    logic [N:0]     sum;
    logic           div_nb;
    logic           div_zero;
    logic           last;
    logic [2*N-1:0] mul_next;
    logic [2*N-1:0] div_next;
    logic [2*N-1:0] prod_next;
    logic [N-1:0]   res_n;
    logic [N-1:0]   rem_n;
    logic           err_n;

    assign busy = state != IDLE;
    assign done = state == DONE;

    // The single shared adder; subtraction is x + ~y + 1.
    always_comb begin
        adder_x   = ~op_r[1] ? a_r
                  : (op_r == OP_MUL ? prod[2*N-1:N] : {prod[2*N-2:N], prod[N-1]});
        adder_y   = op_r == OP_MUL ? (prod[0] ? a_r : '0) : b_r;
        adder_inv = op_r == OP_SUB || op_r == OP_DIV;
        sum       = {1'b0, adder_x} + {1'b0, adder_y ^ {N{adder_inv}}} + (N+1)'(adder_inv);
    end

    // The shifted partial remainder is N+1 bits; its top bit set means it
    // certainly exceeds b, otherwise the adder carry decides (carry = no borrow).
    always_comb begin
        div_nb    = prod[2*N-1] | sum[N];
        mul_next  = {sum, prod[N-1:1]};
        div_next  = {div_nb ? sum[N-1:0] : adder_x, prod[N-2:0], div_nb};
        prod_next = op_r == OP_MUL ? mul_next : div_next;
        div_zero  = op_r == OP_DIV && b_r == '0;
        last      = ~op_r[1] || div_zero || cnt == CW'(N - 1);
    end

    always_comb begin
        res_n = ~op_r[1] ? sum[N-1:0] : (div_zero ? '1 : prod_next[N-1:0]);
        rem_n = op_r != OP_DIV ? '0 : (div_zero ? a_r : prod_next[2*N-1:N]);
        err_n = ~op_r[1] ? sum[N] ^ op_r[0]
              : (op_r == OP_MUL ? |prod_next[2*N-1:N] : div_zero);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= OP_ADD;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            prod      <= '0;
            result    <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r  <= op;
                    a_r   <= a;
                    b_r   <= b;
                    prod  <= {{N{1'b0}}, op == OP_MUL ? b : a};
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    prod <= prod_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        result    <= res_n;
                        remainder <= rem_n;
                        err       <= err_n;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer (N=6)
module tb_calc_sequencer;
    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] remainder;
    logic         err;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .remainder(remainder), .err(err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [1:0] o, input int x, input int y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = N'(x);
        b = N'(y);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy, done, result, remainder, err} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%0b done=%0b result=%0d rem=%0d err=%0b, want all 0",
                     busy, done, result, remainder, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // op, a, b, latency, result, remainder, err
    task automatic run_table(input string name, input int v[][7]);
        int lat;
        foreach (v[i]) begin
            issue(2'(v[i][0]), v[i][1], v[i][2]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] busy after accept: got %0b want 1", name, i, busy);
            end
            wait_done(lat);
            checks++;
            if (lat != v[i][3] || result !== N'(v[i][4]) || remainder !== N'(v[i][5]) || err !== 1'(v[i][6])) begin
                errors++;
                $display("FAIL %s[%0d]: lat=%0d result=%0d rem=%0d err=%0b, want lat=%0d result=%0d rem=%0d err=%0b",
                         name, i, lat, result, remainder, err, v[i][3], v[i][4], v[i][5], v[i][6]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== N'(v[i][4])) begin
                errors++;
                $display("FAIL %s[%0d] after done: done=%0b busy=%0b result=%0d, want 0 0 %0d",
                         name, i, done, busy, result, v[i][4]);
            end
        end
    endtask

    task automatic test_add;
        run_table("add", '{'{0, 50, 20, 1, 6, 0, 1}, '{0, 12, 30, 1, 42, 0, 0}});
    endtask

    task automatic test_sub;
        run_table("sub", '{'{1, 5, 9, 1, 60, 0, 1}, '{1, 40, 15, 1, 25, 0, 0}});
    endtask

    task automatic test_mul;
        run_table("mul", '{'{2, 7, 9, 6, 63, 0, 0}, '{2, 9, 8, 6, 8, 0, 1}, '{2, 0, 63, 6, 0, 0, 0}});
    endtask

    task automatic test_div;
        run_table("div", '{'{3, 45, 7, 6, 6, 3, 0}, '{3, 5, 0, 1, 63, 5, 1}, '{3, 63, 1, 6, 63, 0, 0}});
    endtask

    task automatic test_start_while_busy;
        int lat = 99;
        issue(2'b10, 9, 8);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                start = 1'b1;
                op = 2'b00;
                a = 1;
                b = 1;
            end
            if (done) begin
                lat = k;
                start = 1'b1;
                op = 2'b00;
                break;
            end
        end
        checks++;
        if (lat != 6 || result !== 6'd8 || err !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: lat=%0d result=%0d err=%0b, want lat=6 result=8 err=1", lat, result, err);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_start leave DONE: busy=%0b done=%0b, want 0 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== 6'd8) begin
            errors++;
            $display("FAIL busy_start DONE-start ignored: busy=%0b result=%0d, want 0 8", busy, result);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat;
        logic seen = 1'b0;
        issue(2'b10, 7, 9);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, remainder, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b done=%0b result=%0d rem=%0d err=%0b, want all 0",
                     busy, done, result, remainder, err);
        end
        repeat (8) begin
            @(negedge clk);
            seen |= done;
            if (rst_n == 1'b0) rst_n = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid abandoned: done_seen=%0b busy=%0b, want 0 0", seen, busy);
        end
        issue(2'b00, 1, 1);
        wait_done(lat);
        checks++;
        if (lat != 1 || result !== 6'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid add: lat=%0d result=%0d err=%0b, want 1 2 0", lat, result, err);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_div;
        test_start_while_busy;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
